// File: rtl/pwm_meter_pkg.sv
// ---------------------------------------------------------------------------
// pwm_meter_pkg
// Shared definitions for the PWM duty meter:
//   - meter_state_e : FSM state encoding (IDLE / MEASURE / STUCK)
//   - DEGLITCH_LEN  : consecutive identical samples needed before the
//                     filtered level follows the input (used only when
//                     PWM_DUTY_METER_DEGLITCH_EN is defined)
// ---------------------------------------------------------------------------
package pwm_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } meter_state_e;

    localparam int DEGLITCH_LEN = 3;

endpackage

// File: rtl/pwm_in_cond.sv
// ---------------------------------------------------------------------------
// pwm_in_cond
// Input conditioning for the PWM duty meter: brings the asynchronous PWM
// input into the clk domain, optionally filters short glitches, and flags
// rising edges of the resulting level.
//
// Configuration macro: PWM_DUTY_METER_DEGLITCH_EN
//   defined   : s follows the synchronized input only after DEGLITCH_LEN
//               consecutive identical samples
//   undefined : s is the last synchronizer stage
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   pwm_in in   raw PWM input, asynchronous to clk
//   s      out  filtered, synchronized level
//   rise   out  one-cycle flag: s=1 this cycle and s was 0 last cycle
// ---------------------------------------------------------------------------
module pwm_in_cond
    import pwm_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;
    logic                   s_prev_q;
    logic                   s_prev_d;

    // Shift register synchronizer; bit 0 is the first (metastable) stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PWM_DUTY_METER_DEGLITCH_EN
    localparam int RUN_W = $clog2(DEGLITCH_LEN);

    logic             filt_q;
    logic             filt_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // run_q counts consecutive samples that disagree with the filtered
    // level; the level flips on the DEGLITCH_LEN-th disagreeing sample.
    // Any agreeing sample restarts the count, so short pulses vanish.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_out != filt_q) begin
            if (run_q == RUN_W'(DEGLITCH_LEN - 1)) begin
                filt_d = sync_out;
                run_d  = '0;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync_out;
`endif

    always_comb begin
        s_prev_d = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s_prev_d;
        end
    end

    assign rise = s & ~s_prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// ---------------------------------------------------------------------------
// pwm_duty_meter
// Measures period and high time (in clk cycles) of a PWM waveform and
// reports each completed period; flags an input that stops toggling.
//
// Configuration macro: PWM_DUTY_METER_DEGLITCH_EN (glitch filter inside
// pwm_in_cond; adds DEGLITCH_LEN cycles of latency when defined).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   pwm_in      in   PWM input, asynchronous to clk
//   period_cnt  out  last measured period (cycles)
//   high_cnt    out  last measured high time (cycles)
//   meas_valid  out  one-cycle strobe, asserted in the same cycle that
//                    period_cnt/high_cnt take their new values
//   stuck       out  level; no rising edge for TIMEOUT cycles
//   stuck_level out  filtered input level captured when stuck was set
//
// Handshake: meas_valid is a pure strobe with no ready/back-pressure; a
// consumer must capture period_cnt/high_cnt in the cycle meas_valid is 1.
// FSM state is held in state_q for observation.
// ---------------------------------------------------------------------------
module pwm_duty_meter
    import pwm_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 16'hFFFF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic s;
    logic rise;

    pwm_in_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise)
    );

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] per_run_q, per_run_d;
    logic [CNT_W-1:0] hi_run_q, hi_run_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;

    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] hi_inc;

    // Saturating increments of the running counters.
    always_comb begin
        per_inc = (per_run_q == CNT_MAX) ? per_run_q : per_run_q + CNT_ONE;
        hi_inc  = (s && (hi_run_q != CNT_MAX)) ? hi_run_q + CNT_ONE : hi_run_q;
    end

    always_comb begin
        state_d       = state_q;
        per_run_d     = per_run_q;
        hi_run_d      = hi_run_q;
        period_d      = period_q;
        high_d        = high_q;
        valid_d       = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        case (state_q)
            ST_IDLE, ST_MEASURE: begin
                // An edge wins over a simultaneous timeout.
                if (rise) begin
                    // Counter values cover previous edge (inclusive) up to
                    // this edge (exclusive). In IDLE the span is partial.
                    if (state_q == ST_MEASURE) begin
                        period_d = per_run_q;
                        high_d   = hi_run_q;
                        valid_d  = 1'b1;
                    end
                    per_run_d = CNT_ONE;
                    hi_run_d  = CNT_ONE;
                    state_d   = ST_MEASURE;
                end else if (per_run_q >= TIMEOUT_C) begin
                    state_d       = ST_STUCK;
                    stuck_d       = 1'b1;
                    stuck_level_d = s;
                end else begin
                    per_run_d = per_inc;
                    hi_run_d  = hi_inc;
                end
            end
            ST_STUCK: begin
                // Recovery edge restarts counting, but the period that
                // follows goes through IDLE and is not reported.
                if (rise) begin
                    stuck_d   = 1'b0;
                    per_run_d = CNT_ONE;
                    hi_run_d  = CNT_ONE;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            per_run_q     <= '0;
            hi_run_q      <= '0;
            period_q      <= '0;
            high_q        <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_run_q     <= per_run_d;
            hi_run_q      <= hi_run_d;
            period_q      <= period_d;
            high_q        <= high_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign period_cnt  = period_q;
    assign high_cnt    = high_q;
    assign meas_valid  = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_meter
// Directed bench for pwm_duty_meter (TIMEOUT=64). Stimulus tasks push the
// expected {period, high} of each period that must be reported; a monitor
// pops and compares on every meas_valid.
// ---------------------------------------------------------------------------
module tb_pwm_duty_meter;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    pwm_duty_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .period_cnt  (period_cnt),
        .high_cnt    (high_cnt),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [2*CNT_W-1:0] exp_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 skip = 1;      // upcoming edges that report nothing
    logic [CNT_W-1:0]   prev_p = '0;
    logic [CNT_W-1:0]   prev_h = '0;
    logic [CNT_W-1:0]   last_p = '0;
    logic [CNT_W-1:0]   last_h = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_period"}, 32'(period_cnt), 32'd0);
        check({name, "_high"}, 32'(high_cnt), 32'd0);
        check({name, "_valid"}, 32'(meas_valid), 32'd0);
        check({name, "_stuck"}, 32'(stuck), 32'd0);
        check({name, "_stuck_level"}, 32'(stuck_level), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Called when the bench drives a rising edge that starts a period (p,h).
    // The edge completes the previous period, which is reported unless the
    // meter is still arming after reset or stuck recovery.
    task automatic rise_event(input int p, input int h);
        if (skip > 0) begin
            skip--;
        end else begin
            exp_q.push_back({prev_p, prev_h});
            last_p = prev_p;
            last_h = prev_h;
        end
        prev_p = CNT_W'(p);
        prev_h = CNT_W'(h);
    endtask

    task automatic drive_level(input logic lvl, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 pwm_in = lvl;
        end
    endtask

    task automatic run_period(input int p, input int h);
        rise_event(p, h);
        drive_level(1'b1, h);
        drive_level(1'b0, p - h);
    endtask

    // 10-cycle period: high 3, low 4, one-cycle glitch, low 2.
    task automatic glitch_period();
`ifdef PWM_DUTY_METER_DEGLITCH_EN
        rise_event(10, 3);
        drive_level(1'b1, 3);
        drive_level(1'b0, 4);
        drive_level(1'b1, 1);
        drive_level(1'b0, 2);
`else
        rise_event(7, 3);
        drive_level(1'b1, 3);
        drive_level(1'b0, 4);
        rise_event(3, 1);
        drive_level(1'b1, 1);
        drive_level(1'b0, 2);
`endif
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got period %0d high %0d, expected no strobe (t=%0t)",
                         period_cnt, high_cnt, $time);
            end else begin
                logic [2*CNT_W-1:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({period_cnt, high_cnt} !== e) begin
                    n_err++;
                    $display("FAIL meas: got period %0d high %0d, expected period %0d high %0d (t=%0t)",
                             period_cnt, high_cnt, e[2*CNT_W-1:CNT_W], e[CNT_W-1:0], $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held with the input toggling.
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_level(((i % 3) == 0), 1);
            if (i == 9) check_all_zero("reset_mid");
        end
        check_all_zero("reset_end");
        pwm_in = 1'b0;
        drive_level(1'b0, 3);
        @(negedge clk);
        rst = 1'b0;
        skip = 1;
        drive_level(1'b0, 3);

        // Steady 10/3.
        for (int i = 0; i < 5; i++) run_period(10, 3);

        // Duty change to 20/15.
        for (int i = 0; i < 3; i++) run_period(20, 15);

        // Stuck high.
        rise_event(0, 0);
        drive_level(1'b1, 40);
        check("stuck_early", 32'(stuck), 32'd0);
        drive_level(1'b1, 40);
        check("stuck_set", 32'(stuck), 32'd1);
        check("stuck_level", 32'(stuck_level), 32'd1);
        check("stuck_hold_period", 32'(period_cnt), 32'(last_p));
        check("stuck_hold_high", 32'(high_cnt), 32'(last_h));
        skip = 2;
        drive_level(1'b0, 3);
        check("stuck_after_fall", 32'(stuck), 32'd1);

        // Resume 10/5.
        run_period(10, 5);
        check("stuck_cleared", 32'(stuck), 32'd0);
        for (int i = 0; i < 3; i++) run_period(10, 5);

        // Async reset during the high phase.
        rise_event(0, 0);
        drive_level(1'b1, 6);
        #3 rst = 1'b1;
        #1 check_all_zero("async_reset");
        pwm_in = 1'b0;
        #2 rst = 1'b0;
        skip = 1;
        drive_level(1'b0, 3);
        for (int i = 0; i < 3; i++) run_period(10, 3);

        // Glitches in the low phase.
        glitch_period();
        glitch_period();
        run_period(10, 3);

        // Drain.
        drive_level(1'b0, 20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
